// File: rtl/memory_bus_controller_if.sv
// CPU-side request/ready bus of the work-RAM controller.
// master = CPU, slave = controller.
interface memory_bus_controller_if;
   logic        cpuReq;
   logic        cpuWrite;
   logic [15:0] cpuAddr;
   logic [7:0]  cpuWData;
   logic [7:0]  cpuRData;
   logic        cpuReady;
   logic        busError;

   modport master (
      output cpuReq,
      output cpuWrite,
      output cpuAddr,
      output cpuWData,
      input  cpuRData,
      input  cpuReady,
      input  busError
   );

   modport slave (
      input  cpuReq,
      input  cpuWrite,
      input  cpuAddr,
      input  cpuWData,
      output cpuRData,
      output cpuReady,
      output busError
   );
endinterface

// File: rtl/memory_bus_controller.sv
// Bridges CPU req/ready accesses onto the synchronous work RAM, inserting wait
// states for read latency and answering unmapped addresses with a bus error.
module memory_bus_controller #(
   parameter int          RAM_ADDR_WIDTH = 14,
   parameter logic [15:0] RAM_BASE       = 16'h0000,
   parameter int          READ_LATENCY   = 1,
   parameter logic [7:0]  UNMAPPED_DATA  = 8'hFF
) (
   input  logic                      clk,
   input  logic                      reset,
   memory_bus_controller_if.slave    cpu,
   output logic                      memChipSelect,
   output logic                      memWriteEnable,
   output logic [RAM_ADDR_WIDTH-1:0] memAddress,
   inout  wire  [7:0]                memData
);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      ACK,
      ERR
   } ctrlState;

   ctrlState                  state;
   ctrlState                  nextState;
   logic [RAM_ADDR_WIDTH-1:0] addrReg;
   logic [7:0]                wDataReg;
   logic [7:0]                rDataReg;
   logic [1:0]                waitCount;

   function automatic logic isHit(input logic [15:0] addr);
      isHit = (addr >> RAM_ADDR_WIDTH) == (RAM_BASE >> RAM_ADDR_WIDTH);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (cpu.cpuReq) begin
               if (!isHit(cpu.cpuAddr)) begin
                  nextState = ERR;
               end else if (cpu.cpuWrite) begin
                  nextState = WRITE;
               end else begin
                  nextState = READ;
               end
            end
         end
         WRITE:   nextState = ACK;
         READ:    if (waitCount == 2'd0) nextState = ACK;
         ACK:     nextState = IDLE;
         ERR:     nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // The unmapped-read value is loaded on entry to ERR so it lines up with cpuReady.
   always_ff @(posedge clk) begin
      if (reset) begin
         addrReg   <= '0;
         wDataReg  <= '0;
         rDataReg  <= '0;
         waitCount <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu.cpuReq) begin
                  addrReg   <= cpu.cpuAddr[RAM_ADDR_WIDTH-1:0];
                  wDataReg  <= cpu.cpuWData;
                  waitCount <= 2'(READ_LATENCY);
                  if (!isHit(cpu.cpuAddr) && !cpu.cpuWrite) begin
                     rDataReg <= UNMAPPED_DATA;
                  end
               end
            end
            READ: begin
               if (waitCount != 2'd0) begin
                  waitCount <= waitCount - 2'd1;
               end else begin
                  rDataReg <= memData;
               end
            end
            default: ;
         endcase
      end
   end

   // All outputs decode registered state; the bus is released while reset is held.
   assign memChipSelect  = (state == WRITE) || (state == READ);
   assign memWriteEnable = (state == WRITE);
   assign memAddress     = addrReg;
   assign memData        = ((state == WRITE) && !reset) ? wDataReg : 8'hzz;

   assign cpu.cpuReady = (state == ACK) || (state == ERR);
   assign cpu.busError = (state == ERR);
   assign cpu.cpuRData = rDataReg;

endmodule

// File: tb/tb_memory_bus_controller.sv
// Bench for memory_bus_controller: vector table plus scoreboard on the default
// build, and a second instance with a two-cycle RAM read latency.
module tb_memory_bus_controller;

   typedef struct {
      logic        write;
      logic [15:0] addr;
      logic [7:0]  wdata;
      int          expLat;
      logic        expErr;
      logic [7:0]  expRData;
      int          expCs;
      int          expWe;
   } vecT;

   typedef struct {
      int         reqEdge;
      int         lat;
      logic       err;
      logic [7:0] rdata;
   } sbT;

   logic clk = 1'b0;
   logic reset;
   int   edgeCnt = 0;
   int   checks = 0;
   int   errors = 0;
   sbT   sbQ[$];

   memory_bus_controller_if bus1 ();
   memory_bus_controller_if bus2 ();

   logic        cs1, we1, cs2, we2;
   logic [13:0] addr1, addr2;
   wire  [7:0]  memData1, memData2;

   logic [7:0] ram1 [0:16383];
   logic [7:0] ram2 [0:16383];
   logic [7:0] pipe1;
   logic [7:0] pipe2a, pipe2b;

   always #5 clk = ~clk;

   memory_bus_controller dut1 (
      .clk            (clk),
      .reset          (reset),
      .cpu            (bus1),
      .memChipSelect  (cs1),
      .memWriteEnable (we1),
      .memAddress     (addr1),
      .memData        (memData1)
   );

   memory_bus_controller #(.READ_LATENCY(2)) dut2 (
      .clk            (clk),
      .reset          (reset),
      .cpu            (bus2),
      .memChipSelect  (cs2),
      .memWriteEnable (we2),
      .memAddress     (addr2),
      .memData        (memData2)
   );

   // RAM models: registered read path, pipeline depth equal to read latency
   always @(posedge clk) begin
      if (cs1 && we1) ram1[addr1] <= memData1;
      if (cs1 && !we1) pipe1 <= ram1[addr1];
   end
   assign memData1 = (cs1 && !we1) ? pipe1 : 8'hzz;

   always @(posedge clk) begin
      if (cs2 && we2) ram2[addr2] <= memData2;
      if (cs2 && !we2) begin
         pipe2a <= ram2[addr2];
         pipe2b <= pipe2a;
      end
   end
   assign memData2 = (cs2 && !we2) ? pipe2b : 8'hzz;

   initial forever begin
      @(posedge clk);
      edgeCnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor on the default instance
   initial begin
      logic prevReady;
      sbT   e;
      prevReady = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (bus1.cpuReady) begin
               if (sbQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpectedReady actual=1 expected=0 (t=%0t)", $time);
               end else begin
                  e = sbQ.pop_front();
                  check("latency", 32'(edgeCnt - e.reqEdge + 1), 32'(e.lat));
                  check("busError", {31'd0, bus1.busError}, {31'd0, e.err});
                  check("cpuRData", {24'd0, bus1.cpuRData}, {24'd0, e.rdata});
               end
               check("readyBackToBack", {31'd0, prevReady}, 32'd0);
            end
            if (bus1.busError && !bus1.cpuReady) begin
               check("errWithoutReady", 32'd1, 32'd0);
            end
         end
         prevReady = bus1.cpuReady;
      end
   end

   task automatic runTxn(input vecT v);
      sbT e;
      int csN;
      int weN;
      bit done;
      @(negedge clk);
      bus1.cpuReq   = 1'b1;
      bus1.cpuWrite = v.write;
      bus1.cpuAddr  = v.addr;
      bus1.cpuWData = v.wdata;
      e.reqEdge = edgeCnt + 1;
      e.lat     = v.expLat;
      e.err     = v.expErr;
      e.rdata   = v.expRData;
      sbQ.push_back(e);
      csN  = 0;
      weN  = 0;
      done = 1'b0;
      for (int i = 0; i < 8 && !done; i++) begin
         @(negedge clk);
         bus1.cpuReq = 1'b0;
         if (cs1) begin
            csN++;
            check("memAddress", {18'd0, addr1}, {18'd0, v.addr[13:0]});
         end
         if (we1) begin
            weN++;
            check("memDataWrite", {24'd0, memData1}, {24'd0, v.wdata});
         end
         if (bus1.cpuReady) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL readyTimeout addr=%0h actual=none expected=cpuReady", v.addr);
      end
      check("csCycles", 32'(csN), 32'(v.expCs));
      check("weCycles", 32'(weN), 32'(v.expWe));
   endtask

   initial begin
      vecT vecs[11];
      int  base;
      int  lat2;
      bit  done2;

      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecT vecs[11];
      int  base;
      int  lat2;
      bit  done2;

      vecs[0]  = '{1'b1, 16'h1234, 8'hA5, 2, 1'b0, 8'h00, 1, 1};
      vecs[1]  = '{1'b0, 16'h1234, 8'h00, 3, 1'b0, 8'hA5, 2, 0};
      vecs[2]  = '{1'b0, 16'h8000, 8'h00, 1, 1'b1, 8'hFF, 0, 0};
      vecs[3]  = '{1'b1, 16'hC000, 8'h11, 1, 1'b1, 8'hFF, 0, 0};
      vecs[4]  = '{1'b1, 16'h3FFF, 8'h5A, 2, 1'b0, 8'hFF, 1, 1};
      vecs[5]  = '{1'b1, 16'h0000, 8'h3C, 2, 1'b0, 8'hFF, 1, 1};
      vecs[6]  = '{1'b0, 16'h4000, 8'h00, 1, 1'b1, 8'hFF, 0, 0};
      vecs[7]  = '{1'b0, 16'h3FFF, 8'h00, 3, 1'b0, 8'h5A, 2, 0};
      vecs[8]  = '{1'b0, 16'h0000, 8'h00, 3, 1'b0, 8'h3C, 2, 0};
      vecs[9]  = '{1'b1, 16'hFFFF, 8'h99, 1, 1'b1, 8'h3C, 0, 0};
      vecs[10] = '{1'b0, 16'h1234, 8'h00, 3, 1'b0, 8'hA5, 2, 0};

      for (int i = 0; i < 16384; i++) begin
         ram1[i] = 8'h00;
         ram2[i] = 8'h00;
      end
      ram2[14'h0100] = 8'h77;

      reset         = 1'b1;
      bus1.cpuReq   = 1'b1;
      bus1.cpuWrite = 1'b1;
      bus1.cpuAddr  = 16'h1234;
      bus1.cpuWData = 8'hA5;
      bus2.cpuReq   = 1'b0;
      bus2.cpuWrite = 1'b0;
      bus2.cpuAddr  = 16'h0000;
      bus2.cpuWData = 8'h00;

      // Reset held two cycles with a pending request
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rstReady", {31'd0, bus1.cpuReady}, 32'd0);
         check("rstBusError", {31'd0, bus1.busError}, 32'd0);
         check("rstRData", {24'd0, bus1.cpuRData}, 32'd0);
         check("rstCs", {31'd0, cs1}, 32'd0);
         check("rstWe", {31'd0, we1}, 32'd0);
         check("rstAddr", {18'd0, addr1}, 32'd0);
      end
      reset       = 1'b0;
      bus1.cpuReq = 1'b0;
      @(negedge clk);
      check("postRstCs", {31'd0, cs1}, 32'd0);
      check("postRstReady", {31'd0, bus1.cpuReady}, 32'd0);

      for (int i = 0; i < 11; i++) begin
         runTxn(vecs[i]);
      end

      // Back-to-back reads with cpuReq held high
      @(negedge clk);
      bus1.cpuReq   = 1'b1;
      bus1.cpuWrite = 1'b0;
      bus1.cpuAddr  = 16'h1234;
      base = edgeCnt + 1;
      sbQ.push_back('{base, 3, 1'b0, 8'hA5});
      sbQ.push_back('{base + 4, 3, 1'b0, 8'hA5});
      repeat (4) @(negedge clk);
      check("gapCs", {31'd0, cs1}, 32'd0);
      check("gapReady", {31'd0, bus1.cpuReady}, 32'd0);
      @(negedge clk);
      bus1.cpuReq = 1'b0;
      check("secondReadCs", {31'd0, cs1}, 32'd1);
      repeat (3) @(negedge clk);
      check("sbDrainB2B", 32'(sbQ.size()), 32'd0);

      // Reset during the second READ cycle
      @(negedge clk);
      bus1.cpuReq   = 1'b1;
      bus1.cpuWrite = 1'b0;
      bus1.cpuAddr  = 16'h3FFF;
      @(negedge clk);
      bus1.cpuReq = 1'b0;
      @(negedge clk);
      check("midReadCs", {31'd0, cs1}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("abortCs", {31'd0, cs1}, 32'd0);
      check("abortReady", {31'd0, bus1.cpuReady}, 32'd0);
      check("abortRData", {24'd0, bus1.cpuRData}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("abortIdleCs", {31'd0, cs1}, 32'd0);
      check("abortIdleReady", {31'd0, bus1.cpuReady}, 32'd0);

      // Two-cycle read latency instance
      @(negedge clk);
      bus2.cpuReq   = 1'b1;
      bus2.cpuWrite = 1'b0;
      bus2.cpuAddr  = 16'h0100;
      base  = edgeCnt + 1;
      lat2  = 0;
      done2 = 1'b0;
      for (int i = 0; i < 8 && !done2; i++) begin
         @(negedge clk);
         bus2.cpuReq = 1'b0;
         if (bus2.cpuReady) begin
            done2 = 1'b1;
            lat2  = edgeCnt - base + 1;
            check("lat2RData", {24'd0, bus2.cpuRData}, 32'h77);
            check("lat2BusError", {31'd0, bus2.busError}, 32'd0);
         end
      end
      if (!done2) begin
         checks++;
         errors++;
         $display("FAIL lat2Timeout actual=none expected=cpuReady");
      end
      check("lat2Latency", 32'(lat2), 32'd4);

      repeat (2) @(negedge clk);
      check("sbEmpty", 32'(sbQ.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_bus_controller.md
Name: memory_bus_controller

Overview:
- CPU-side bus controller sitting directly upstream of the 16 kB system work RAM.
- Converts a CPU req/ready memory request on a 16-bit address space into the RAM's chip-select, write-enable, 14-bit address and shared 8-bit bidirectional data bus.
- Compensates for the RAM's synchronous read latency with wait states.
- Addresses outside the RAM window complete immediately with a bus-error flag; the RAM is never selected for them.

Parameters:
- RAM_ADDR_WIDTH, 14, RAM address width; window size = 2^RAM_ADDR_WIDTH bytes.
- RAM_BASE, 16'h0000, CPU base address of the RAM window; must be aligned to the window size.
- READ_LATENCY, 1, RAM clock edges from address sample to valid read data (1..3).
- UNMAPPED_DATA, 8'hFF, value returned on reads of unmapped addresses.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- cpuReq  input  1  request strobe; sampled only in IDLE.
- cpuWrite  input  1  1 = write, 0 = read; sampled with cpuReq.
- cpuAddr  input  16  CPU byte address.
- cpuWData  input  8  write data.
- cpuRData  output  8  read data; held until the next completed read.
- cpuReady  output  1  one-cycle completion pulse.
- busError  output  1  one-cycle pulse coincident with cpuReady on an unmapped access.
- memChipSelect  output  1  RAM chip select.
- memWriteEnable  output  1  RAM write enable.
- memAddress  output  RAM_ADDR_WIDTH  RAM address.
- memData  inout  8  shared RAM data bus.

Behaviour:
- Clocking: single clock domain (clk). reset is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - cpuReady = 0, busError = 0, cpuRData = 8'h00.
  - memChipSelect = 0, memWriteEnable = 0, memAddress = 0.
  - memData = Z.
  - Internal address, data, write and count registers are cleared.
- Address decode: hit when cpuAddr >> RAM_ADDR_WIDTH == RAM_BASE >> RAM_ADDR_WIDTH. RAM address = cpuAddr[RAM_ADDR_WIDTH-1:0]. No wrap-around: 0x3FFF+1 = 0x4000 is unmapped with the defaults.
- FSM states: IDLE, WRITE, READ, ACK, ERR.
  - IDLE:
    - cpuReq=1 latches cpuAddr, cpuWData and cpuWrite.
    - Next state: hit & write → WRITE; hit & read → READ with count=READ_LATENCY; miss → ERR.
    - cpuReq=0 → stay in IDLE.
  - WRITE (exactly 1 cycle):
    - memChipSelect=1, memWriteEnable=1, memAddress=latched address.
    - memData driven with latched data.
    - Next state: ACK.
  - READ (READ_LATENCY+1 cycles):
    - memChipSelect=1, memWriteEnable=0, memAddress=latched address, memData=Z.
    - At each edge: if count≠0, decrement; if count==0, capture memData into cpuRData and go to ACK.
  - ACK (1 cycle): cpuReady=1, chip select deasserted. Next state: IDLE.
  - ERR (1 cycle):
    - cpuReady=1, busError=1.
    - On reads, cpuRData=UNMAPPED_DATA; on writes, cpuRData is unchanged.
    - Next state: IDLE.
- Latency (edges from the edge sampling cpuReq to the cycle with cpuReady high):
  - Write: 2.
  - Read: READ_LATENCY+2 (3 with the defaults).
  - Unmapped: 1.
- Throughput: cpuReq is ignored outside IDLE. A cpuReq held high through ACK/ERR starts a new transaction at the following IDLE cycle, giving a minimum 1-cycle IDLE gap between transactions.
- Bus contention rule: memData is driven only in WRITE, which is also the only state with memWriteEnable=1. It is Z in every other state, including during reset.
- memAddress holds its last value when idle. memChipSelect is 0 in IDLE, ACK and ERR.
- Outputs are decoded from registered state only; no combinational path from cpu* inputs to any output.
- Reset mid-transaction:
  - Reset has priority over everything, including a simultaneous cpuReq.
  - Next cycle is IDLE with chip select deasserted and no cpuReady pulse.
  - A write interrupted in WRITE may or may not have reached RAM; the CPU must reissue it.
- cpuRData changes only on a completed mapped read, an unmapped read, or reset.

Test Plan:
1. Assert reset for 2 cycles with cpuReq=1 → cpuReady=0, busError=0, cpuRData=00, memChipSelect=0, memWriteEnable=0, memData=Z, state stays IDLE.
2. Write 0x1234←0xA5, then read 0x1234 →
   - Write: cpuReady at edge 2; exactly one cycle with memChipSelect=1, memWriteEnable=1, memAddress=0x1234, memData=A5.
   - Read: cpuReady at edge 3, cpuRData=A5, memData never driven by the controller.
3. Read 0x8000, then write 0xC000←0x11 →
   - Read: cpuReady and busError at edge 1, cpuRData=FF.
   - Write: cpuReady and busError at edge 1, cpuRData stays FF.
   - memChipSelect stays 0 throughout.
4. Boundaries: write 0x3FFF←0x5A and 0x0000←0x3C, then read 0x4000, 0x3FFF, 0x0000 →
   - Read 0x4000 errors.
   - Read 0x3FFF returns 5A.
   - Read 0x0000 returns 3C (no aliasing).
5. cpuReq held high across two back-to-back reads → each takes READ_LATENCY+2 edges, a 1-cycle IDLE gap separates them, and cpuReady is never asserted two cycles in a row.
6. Assert reset on the second READ cycle → next cycle IDLE, memChipSelect=0, no cpuReady pulse, cpuRData=00. Separately, with READ_LATENCY=2, a read of 0x0100 completes at edge 4 with correct data.
